// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared core package: fetch FSM states and fetch/PC constants.
// Imported by the fetch redirect controller and its hazard detector.
package core_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          INSTR_BYTES  = 4;
    localparam int          REG_ADDR_W   = 5;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Instruction-memory request/response handshake between the fetch
// controller (master) and imem (slave).
interface fetch_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            io_imem_req_valid;
    logic            io_imem_req_ready;
    logic [XLEN-1:0] io_imem_req_addr;
    logic            io_imem_resp_valid;
    logic            io_imem_resp_ready;

    modport master (
        output io_imem_req_valid,
        input  io_imem_req_ready,
        output io_imem_req_addr,
        input  io_imem_resp_valid,
        output io_imem_resp_ready
    );

    modport slave (
        input  io_imem_req_valid,
        output io_imem_req_ready,
        input  io_imem_req_addr,
        output io_imem_resp_valid,
        input  io_imem_resp_ready
    );
endinterface

// File: rtl/fetch_redirect_ctrl_load_use_detect.sv
// Load-use hazard term: EX load whose destination feeds an ID source.
// Register x0 never creates a dependency.
module load_use_detect
    import core_pkg::*;
(
    input  logic                  i_ex_memread,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    output logic                  o_hazard
);
    logic w_rd_nz;
    logic w_match;

    assign w_rd_nz  = (i_ex_rd != '0);
    assign w_match  = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
    assign o_hazard = i_ex_memread & w_rd_nz & w_match;
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: single-outstanding imem fetch, branch redirect with
// stale-fetch kill, load-use bubbles and a saturating redirect counter.
module fetch_redirect_ctrl #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = core_pkg::RESET_VECTOR,
    parameter int          INSTR_BYTES  = core_pkg::INSTR_BYTES,
    parameter logic [31:0] CNT_RESET    = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_mem_pcsrc,
    input  logic [XLEN-1:0] io_mem_target,
    input  logic            io_ex_memread,
    input  logic [4:0]      io_ex_rd,
    input  logic [4:0]      io_id_rs1,
    input  logic [4:0]      io_id_rs2,
    fetch_redirect_ctrl_if.master imem,
    output logic            io_if_valid,
    output logic            io_stall_if_id,
    output logic            io_flush_if_id,
    output logic            io_flush_id_ex,
    output logic            io_flush_ex_mem,
    output logic [XLEN-1:0] io_pc,
    output logic [31:0]     io_redirect_count
);
    import core_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [31:0]     r_count;

    logic w_hazard;
    logic w_redir;
    logic w_stall;
    logic w_req_hs;
    logic w_resp_hs;

    load_use_detect u_lud (
        .i_ex_memread (io_ex_memread),
        .i_ex_rd      (io_ex_rd),
        .i_id_rs1     (io_id_rs1),
        .i_id_rs2     (io_id_rs2),
        .o_hazard     (w_hazard)
    );

    // Everything combinational is forced low while reset is held.
    assign w_redir = reset & io_mem_pcsrc;
    assign w_stall = reset & w_hazard & ~io_mem_pcsrc;

    always_comb begin
        imem.io_imem_req_valid  = 1'b0;
        imem.io_imem_resp_ready = 1'b0;
        unique case (r_state)
            RUN:     imem.io_imem_req_valid  = reset & ~w_stall;
            WAIT:    imem.io_imem_resp_ready = reset & ~w_stall;
            KILL:    imem.io_imem_resp_ready = reset;
            default: ;
        endcase
    end

    assign imem.io_imem_req_addr = r_pc;

    assign w_req_hs  = imem.io_imem_req_valid & imem.io_imem_req_ready;
    assign w_resp_hs = imem.io_imem_resp_valid & imem.io_imem_resp_ready;

    assign io_if_valid     = (r_state == WAIT) & w_resp_hs & ~w_redir;
    assign io_stall_if_id  = w_stall;
    assign io_flush_if_id  = w_redir;
    assign io_flush_id_ex  = w_redir | w_stall;
    assign io_flush_ex_mem = w_redir;
    assign io_pc             = r_pc;
    assign io_redirect_count = r_count;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            RUN: begin
                if (w_redir)       w_state_nxt = w_req_hs ? KILL : RUN;
                else if (w_req_hs) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_redir) begin
                    w_state_nxt = w_resp_hs ? RUN : KILL;
                end else if (w_resp_hs) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = r_pc + PC_STEP;
                end
            end
            KILL: begin
                // A redirect keeps waiting for the stale response unless it lands now.
                if (w_resp_hs) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
        if (w_redir) w_pc_nxt = io_mem_target & ALIGN_MASK;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_pc    <= XLEN'(RESET_VECTOR);
            r_count <= CNT_RESET;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_redir && (r_count != 32'hFFFF_FFFF)) begin
                r_count <= r_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench: expected handshakes and flush patterns are queued by the
// stimulus and popped by a negedge monitor; PC/count are checked inline.
module tb_fetch_redirect_ctrl;
    logic        clock;
    logic        reset;
    logic        pcsrc;
    logic [31:0] target;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;

    logic        if_valid, stall, f_ifid, f_idex, f_exmem;
    logic [31:0] pc, cnt;

    logic        if_valid2, stall2, f_ifid2, f_idex2, f_exmem2;
    logic [31:0] pc2, cnt2;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_req[$];
    logic        q_resp[$];
    logic [3:0]  q_flush[$];

    fetch_redirect_ctrl_if #(.XLEN(32)) imem_if ();
    fetch_redirect_ctrl_if #(.XLEN(32)) imem_if2 ();

    fetch_redirect_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .io_mem_pcsrc      (pcsrc),
        .io_mem_target     (target),
        .io_ex_memread     (ex_memread),
        .io_ex_rd          (ex_rd),
        .io_id_rs1         (id_rs1),
        .io_id_rs2         (id_rs2),
        .imem              (imem_if.master),
        .io_if_valid       (if_valid),
        .io_stall_if_id    (stall),
        .io_flush_if_id    (f_ifid),
        .io_flush_id_ex    (f_idex),
        .io_flush_ex_mem   (f_exmem),
        .io_pc             (pc),
        .io_redirect_count (cnt)
    );

    fetch_redirect_ctrl #(.CNT_RESET(32'hFFFF_FFFE)) dut_sat (
        .clock             (clock),
        .reset             (reset),
        .io_mem_pcsrc      (pcsrc),
        .io_mem_target     (target),
        .io_ex_memread     (ex_memread),
        .io_ex_rd          (ex_rd),
        .io_id_rs1         (id_rs1),
        .io_id_rs2         (id_rs2),
        .imem              (imem_if2.master),
        .io_if_valid       (if_valid2),
        .io_stall_if_id    (stall2),
        .io_flush_if_id    (f_ifid2),
        .io_flush_id_ex    (f_idex2),
        .io_flush_ex_mem   (f_exmem2),
        .io_pc             (pc2),
        .io_redirect_count (cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_one(input logic [31:0] addr);
        q_req.push_back(addr);
        step();
        imem_if.io_imem_resp_valid = 1'b1;
        q_resp.push_back(1'b1);
        step();
        imem_if.io_imem_resp_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (imem_if.io_imem_req_valid && imem_if.io_imem_req_ready) begin
            if (q_req.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_unexpected: got addr %h expected none",
                         imem_if.io_imem_req_addr);
            end else begin
                check("req_addr", imem_if.io_imem_req_addr, q_req.pop_front());
            end
        end
        if (imem_if.io_imem_resp_valid && imem_if.io_imem_resp_ready) begin
            if (q_resp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL resp_unexpected: got if_valid %b expected none",
                         if_valid);
            end else begin
                check("if_valid", {31'd0, if_valid}, {31'd0, q_resp.pop_front()});
            end
        end else if (if_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL if_valid_no_hs: got 1 expected 0");
        end
        if (stall | f_ifid | f_idex | f_exmem) begin
            if (q_flush.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL flush_unexpected: got %b expected none",
                         {stall, f_ifid, f_idex, f_exmem});
            end else begin
                check("stall_flush", {28'd0, stall, f_ifid, f_idex, f_exmem},
                      {28'd0, q_flush.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        reset = 1'b0;
        pcsrc = 1'b0;
        target = '0;
        ex_memread = 1'b0;
        ex_rd = '0;
        id_rs1 = '0;
        id_rs2 = '0;
        imem_if.io_imem_req_ready  = 1'b1;
        imem_if.io_imem_resp_valid = 1'b0;
        imem_if2.io_imem_req_ready  = 1'b0;
        imem_if2.io_imem_resp_valid = 1'b0;

        // reset state
        step();
        step();
        check("rst_req_valid", {31'd0, imem_if.io_imem_req_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_count", cnt, 32'h0);
        check("rst_count_sat", cnt2, 32'hFFFF_FFFE);
        reset = 1'b1;

        // sequential fetches 0x0, 0x4, 0x8
        fetch_one(32'h0);
        fetch_one(32'h4);
        fetch_one(32'h8);
        check("seq_pc", pc, 32'hC);

        // redirect while WAIT, no response -> KILL
        q_req.push_back(32'hC);
        step();
        pcsrc = 1'b1;
        target = 32'h100;
        q_flush.push_back(4'b0111);
        step();
        pcsrc = 1'b0;
        check("kill_pc", pc, 32'h100);
        check("kill_count", cnt, 32'd1);
        check("kill_count_sat", cnt2, 32'hFFFF_FFFF);
        check("kill_req_valid", {31'd0, imem_if.io_imem_req_valid}, 32'd0);
        imem_if.io_imem_resp_valid = 1'b1;
        q_resp.push_back(1'b0);
        step();
        imem_if.io_imem_resp_valid = 1'b0;
        fetch_one(32'h100);

        // redirect coincident with response, unaligned target
        q_req.push_back(32'h104);
        step();
        imem_if.io_imem_resp_valid = 1'b1;
        pcsrc = 1'b1;
        target = 32'h203;
        q_resp.push_back(1'b0);
        q_flush.push_back(4'b0111);
        step();
        imem_if.io_imem_resp_valid = 1'b0;
        pcsrc = 1'b0;
        check("same_pc", pc, 32'h200);
        check("same_count", cnt, 32'd2);
        check("same_count_sat", cnt2, 32'hFFFF_FFFF);
        fetch_one(32'h200);

        // load-use in WAIT holds the response
        q_req.push_back(32'h204);
        step();
        imem_if.io_imem_resp_valid = 1'b1;
        ex_memread = 1'b1;
        ex_rd = 5'd5;
        id_rs2 = 5'd5;
        q_flush.push_back(4'b1010);
        #1;
        check("lu_resp_ready", {31'd0, imem_if.io_imem_resp_ready}, 32'd0);
        step();
        check("lu_pc_held", pc, 32'h204);
        ex_rd = 5'd0;
        id_rs2 = 5'd0;
        q_resp.push_back(1'b1);
        #1;
        check("x0_no_stall", {31'd0, stall}, 32'd0);
        check("x0_resp_ready", {31'd0, imem_if.io_imem_resp_ready}, 32'd1);
        step();
        imem_if.io_imem_resp_valid = 1'b0;
        ex_memread = 1'b0;
        check("x0_pc", pc, 32'h208);

        // hazard and redirect together
        q_req.push_back(32'h208);
        step();
        ex_memread = 1'b1;
        ex_rd = 5'd7;
        id_rs1 = 5'd7;
        pcsrc = 1'b1;
        target = 32'h300;
        q_flush.push_back(4'b0111);
        #1;
        check("hz_redir_stall", {31'd0, stall}, 32'd0);
        step();
        pcsrc = 1'b0;
        ex_memread = 1'b0;
        ex_rd = '0;
        id_rs1 = '0;
        check("hz_redir_pc", pc, 32'h300);
        check("hz_redir_count", cnt, 32'd3);
        check("hz_redir_sat", cnt2, 32'hFFFF_FFFF);
        imem_if.io_imem_resp_valid = 1'b1;
        q_resp.push_back(1'b0);
        step();
        imem_if.io_imem_resp_valid = 1'b0;

        // reset asserted mid-WAIT
        q_req.push_back(32'h300);
        step();
        imem_if.io_imem_resp_valid = 1'b1;
        reset = 1'b0;
        #1;
        check("mid_rst_req_valid", {31'd0, imem_if.io_imem_req_valid}, 32'd0);
        check("mid_rst_resp_ready", {31'd0, imem_if.io_imem_resp_ready}, 32'd0);
        check("mid_rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_count", cnt, 32'h0);
        step();
        imem_if.io_imem_resp_valid = 1'b0;
        reset = 1'b1;
        fetch_one(32'h0);
        imem_if.io_imem_req_ready = 1'b0;
        step();
        step();
        check("end_pc", pc, 32'h4);
        check("q_req_empty", q_req.size(), 32'd0);
        check("q_resp_empty", q_resp.size(), 32'd0);
        check("q_flush_empty", q_flush.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
